// File: rtl/softmax_sched_pkg.sv
// Shared constants, state encoding and latched layer configuration for the
// softmax tile scheduler and its address generator.
package softmax_sched_pkg;

  localparam int ADDR_W      = 32;
  localparam int DIM_W       = 16;
  localparam int BURST_LEN   = 16;
  localparam int PIXEL_BYTES = 32;
  localparam int TOUT        = 8;
  localparam int BURST_BYTES = BURST_LEN * PIXEL_BYTES;
  localparam int PIX_W       = $clog2(BURST_LEN) + 1;
  localparam int LANE_W      = $clog2(TOUT) + 1;

  typedef enum logic [2:0] {
    IDLE,
    CHK,
    P1_RD,
    P1_WAIT,
    P2_RD,
    P2_WR,
    P2_WAIT,
    FIN
  } sched_state_t;

  typedef struct packed {
    logic [DIM_W-1:0]  head;
    logic [DIM_W-1:0]  win;
    logic [DIM_W-1:0]  ch_groups;
    logic [DIM_W-1:0]  height;
    logic [DIM_W-1:0]  width_in;
    logic [ADDR_W-1:0] in_base;
    logic [ADDR_W-1:0] in_surf;
    logic [ADDR_W-1:0] in_line;
    logic [ADDR_W-1:0] out_base;
    logic [ADDR_W-1:0] out_surf;
    logic [ADDR_W-1:0] out_line;
  } sched_cfg_t;

endpackage

// File: rtl/softmax_addr_gen.sv
// Tile/group counters with incremental address accumulators; the FSM only
// tells it when to restart, step a group, rewind groups, or step a tile.
module softmax_addr_gen
  import softmax_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  sched_cfg_t        cfg,
  input  logic              restart_layer,
  input  logic              step_g,
  input  logic              restart_g,
  input  logic              step_tile,
  output logic [ADDR_W-1:0] in_addr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [PIX_W-1:0]  pix_cnt,
  output logic [LANE_W-1:0] lane_cnt,
  output logic              last_g,
  output logic              last_tile
);

  localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_BYTES);
  localparam logic [DIM_W:0]    BURST_PIX  = (DIM_W+1)'(BURST_LEN);
  localparam logic [DIM_W-1:0]  TOUT_STEP  = DIM_W'(TOUT);
  localparam logic [LANE_W-1:0] TOUT_LANES = LANE_W'(TOUT);
  localparam logic [PIX_W-1:0]  FULL_PIX   = PIX_W'(BURST_LEN);
  localparam logic [DIM_W-1:0]  ONE_DIM    = DIM_W'(1);

  logic [DIM_W-1:0]  h_cnt;
  logic [DIM_W-1:0]  g_cnt;
  logic [DIM_W-1:0]  ch_off;
  logic [DIM_W:0]    pix_off;
  logic [ADDR_W-1:0] line_in;
  logic [ADDR_W-1:0] tile_in;
  logic [ADDR_W-1:0] line_out;
  logic [ADDR_W-1:0] tile_out;
  logic [ADDR_W-1:0] next_tile_in;
  logic [ADDR_W-1:0] next_tile_out;
  logic              last_h;
  logic              last_wb;

  // pix_off tracks wb*BURST_LEN, so the burst counter is implicit in it
  assign last_g    = (g_cnt == cfg.ch_groups - ONE_DIM);
  assign last_h    = (h_cnt == cfg.head - ONE_DIM);
  assign last_wb   = ((pix_off + BURST_PIX) >= {1'b0, cfg.win});
  assign last_tile = last_h && last_wb;

  always_comb begin
    if (last_wb) begin
      next_tile_in  = line_in + cfg.in_line;
      next_tile_out = line_out + cfg.out_line;
    end else begin
      next_tile_in  = tile_in + BURST_STEP;
      next_tile_out = tile_out + BURST_STEP;
    end
  end

  always_comb begin
    if ({1'b0, cfg.height} <= pix_off) begin
      pix_cnt = '0;
    end else if (({1'b0, cfg.height} - pix_off) >= BURST_PIX) begin
      pix_cnt = FULL_PIX;
    end else begin
      pix_cnt = PIX_W'({1'b0, cfg.height} - pix_off);
    end
  end

  // Only the final group can be partial; the modulo-2^LANE_W subtraction is exact there
  always_comb begin
    if (last_g) begin
      lane_cnt = LANE_W'(cfg.width_in - ch_off);
    end else begin
      lane_cnt = TOUT_LANES;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt    <= '0;
      g_cnt    <= '0;
      ch_off   <= '0;
      pix_off  <= '0;
      line_in  <= '0;
      tile_in  <= '0;
      line_out <= '0;
      tile_out <= '0;
      in_addr  <= '0;
      out_addr <= '0;
    end else if (restart_layer) begin
      h_cnt    <= '0;
      g_cnt    <= '0;
      ch_off   <= '0;
      pix_off  <= '0;
      line_in  <= cfg.in_base;
      tile_in  <= cfg.in_base;
      in_addr  <= cfg.in_base;
      line_out <= cfg.out_base;
      tile_out <= cfg.out_base;
      out_addr <= cfg.out_base;
    end else if (step_tile) begin
      g_cnt    <= '0;
      ch_off   <= '0;
      tile_in  <= next_tile_in;
      in_addr  <= next_tile_in;
      tile_out <= next_tile_out;
      out_addr <= next_tile_out;
      if (last_wb) begin
        pix_off  <= '0;
        h_cnt    <= h_cnt + ONE_DIM;
        line_in  <= next_tile_in;
        line_out <= next_tile_out;
      end else begin
        pix_off <= pix_off + BURST_PIX;
      end
    end else if (restart_g) begin
      g_cnt    <= '0;
      ch_off   <= '0;
      in_addr  <= tile_in;
      out_addr <= tile_out;
    end else if (step_g) begin
      g_cnt    <= g_cnt + ONE_DIM;
      ch_off   <= ch_off + TOUT_STEP;
      in_addr  <= in_addr + cfg.in_surf;
      out_addr <= out_addr + cfg.out_surf;
    end
  end

endmodule

// File: rtl/softmax_tile_scheduler.sv
// Two-pass descriptor sequencer for the softmax engine. Optional busy/stall
// performance counters are built when SOFTMAX_SCHED_PERF_EN is defined.
module softmax_tile_scheduler
  import softmax_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_head,
  input  logic [DIM_W-1:0]  cfg_win,
  input  logic [DIM_W-1:0]  cfg_ch_groups,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic [DIM_W-1:0]  cfg_width_in,
  input  logic [ADDR_W-1:0] cfg_in_base,
  input  logic [ADDR_W-1:0] cfg_in_surf,
  input  logic [ADDR_W-1:0] cfg_in_line,
  input  logic [ADDR_W-1:0] cfg_out_base,
  input  logic [ADDR_W-1:0] cfg_out_surf,
  input  logic [ADDR_W-1:0] cfg_out_line,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_pass,
  output logic              rd_last_grp,
  output logic [PIX_W-1:0]  rd_pix_cnt,
  output logic [LANE_W-1:0] rd_lane_cnt,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              pass_done,
  output logic              busy,
`ifdef SOFTMAX_SCHED_PERF_EN
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stall,
`endif
  output logic              done
);

  sched_state_t      state;
  sched_state_t      state_next;
  sched_cfg_t        cfg_q;
  logic              start_accept;
  logic              restart_layer;
  logic              step_g;
  logic              restart_g;
  logic              step_tile;
  logic [ADDR_W-1:0] gen_in_addr;
  logic [ADDR_W-1:0] gen_out_addr;
  logic [PIX_W-1:0]  gen_pix_cnt;
  logic [LANE_W-1:0] gen_lane_cnt;
  logic              last_g;
  logic              last_tile;

  assign start_accept = (state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= '0;
    end else if (start_accept) begin
      cfg_q <= '{head: cfg_head, win: cfg_win, ch_groups: cfg_ch_groups,
                 height: cfg_height, width_in: cfg_width_in,
                 in_base: cfg_in_base, in_surf: cfg_in_surf, in_line: cfg_in_line,
                 out_base: cfg_out_base, out_surf: cfg_out_surf, out_line: cfg_out_line};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CHK;
      CHK: begin
        if ((cfg_q.head == '0) || (cfg_q.win == '0) || (cfg_q.ch_groups == '0)) begin
          state_next = FIN;
        end else begin
          state_next = P1_RD;
        end
      end
      P1_RD:   if (rd_ready && last_g) state_next = P1_WAIT;
      P1_WAIT: if (pass_done) state_next = P2_RD;
      P2_RD:   if (rd_ready) state_next = P2_WR;
      P2_WR:   if (wr_ready) state_next = last_g ? P2_WAIT : P2_RD;
      P2_WAIT: if (pass_done) state_next = last_tile ? FIN : P1_RD;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Valids come from state alone; ready only decides how the counters move
  always_comb begin
    rd_valid      = 1'b0;
    rd_pass       = 1'b0;
    wr_valid      = 1'b0;
    done          = 1'b0;
    busy          = 1'b0;
    restart_layer = 1'b0;
    step_g        = 1'b0;
    restart_g     = 1'b0;
    step_tile     = 1'b0;
    case (state)
      CHK: begin
        busy          = 1'b1;
        restart_layer = 1'b1;
      end
      P1_RD: begin
        busy     = 1'b1;
        rd_valid = 1'b1;
        if (rd_ready) begin
          step_g    = !last_g;
          restart_g = last_g;
        end
      end
      P1_WAIT: busy = 1'b1;
      P2_RD: begin
        busy     = 1'b1;
        rd_valid = 1'b1;
        rd_pass  = 1'b1;
      end
      P2_WR: begin
        busy     = 1'b1;
        wr_valid = 1'b1;
        if (wr_ready) begin
          step_g    = !last_g;
          restart_g = last_g;
        end
      end
      P2_WAIT: begin
        busy      = 1'b1;
        step_tile = pass_done;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  softmax_addr_gen u_addr_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg           (cfg_q),
    .restart_layer (restart_layer),
    .step_g        (step_g),
    .restart_g     (restart_g),
    .step_tile     (step_tile),
    .in_addr       (gen_in_addr),
    .out_addr      (gen_out_addr),
    .pix_cnt       (gen_pix_cnt),
    .lane_cnt      (gen_lane_cnt),
    .last_g        (last_g),
    .last_tile     (last_tile)
  );

  // Payload is masked outside its valid so idle outputs read as zero
  assign rd_addr     = rd_valid ? gen_in_addr : '0;
  assign rd_pix_cnt  = rd_valid ? gen_pix_cnt : '0;
  assign rd_lane_cnt = rd_valid ? gen_lane_cnt : '0;
  assign rd_last_grp = rd_valid && last_g;
  assign wr_addr     = wr_valid ? gen_out_addr : '0;

`ifdef SOFTMAX_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (start_accept) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy && !(&perf_cycles)) begin
        perf_cycles <= perf_cycles + 32'd1;
      end
      if (((rd_valid && !rd_ready) || (wr_valid && !wr_ready)) && !(&perf_stall)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_softmax_tile_scheduler.sv
// Scoreboard bench: a loop-nest reference model queues expected descriptors,
// a negedge monitor pops and compares on every accepted handshake.
`timescale 1ns/1ps
module tb_softmax_tile_scheduler;

  localparam int TB_BURST = 16;
  localparam int TB_PIXB  = 32;
  localparam int TB_TOUT  = 8;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    bit          pass;
    bit          last;
    int          pix;
    int          lane;
    int          h;
    int          wb;
    int          g;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] c_head = '0, c_win = '0, c_cg = '0, c_height = '0, c_width = '0;
  logic [31:0] c_inb = '0, c_ins = '0, c_inl = '0, c_outb = '0, c_outs = '0, c_outl = '0;
  logic        rd_valid, rd_pass, rd_last_grp, wr_valid, busy, done;
  logic        rd_ready = 1'b1, wr_ready = 1'b1, pass_done = 1'b0;
  logic [31:0] rd_addr, wr_addr;
  logic [4:0]  rd_pix_cnt;
  logic [3:0]  rd_lane_cnt;

  exp_t sb[$];
  int   total = 0, bad = 0;
  int   cyc = 0, pd_due = -1;
  bit   spur_pd = 0, rand_rdy = 0, hold_rdy = 1, spot_check = 0;
  bit   gap = 0;
  int   stray = 0;
  int   rd_seen = 0, wr_seen = 0, done_cnt = 0, valid_cycles = 0;
  int   rd0, wr0, done0, valid0;

  softmax_tile_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_head(c_head), .cfg_win(c_win), .cfg_ch_groups(c_cg),
    .cfg_height(c_height), .cfg_width_in(c_width),
    .cfg_in_base(c_inb), .cfg_in_surf(c_ins), .cfg_in_line(c_inl),
    .cfg_out_base(c_outb), .cfg_out_surf(c_outs), .cfg_out_line(c_outl),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_pass(rd_pass),
    .rd_last_grp(rd_last_grp), .rd_pix_cnt(rd_pix_cnt), .rd_lane_cnt(rd_lane_cnt),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .pass_done(pass_done), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: walk the loop nest with plain arithmetic
  task automatic buildExpected(output int n_rd, output int n_wr);
    n_rd = 0;
    n_wr = 0;
    if (c_head == 0 || c_win == 0 || c_cg == 0) return;
    for (int h = 0; h < int'(c_head); h++)
      for (int wb = 0; wb < int'(c_win) / TB_BURST; wb++)
        for (int p = 0; p < 2; p++)
          for (int g = 0; g < int'(c_cg); g++) begin
            exp_t e;
            int rem;
            rem    = int'(c_height) - wb * TB_BURST;
            e.h    = h;
            e.wb   = wb;
            e.g    = g;
            e.pass = (p == 1);
            e.last = (g == int'(c_cg) - 1);
            e.pix  = (rem <= 0) ? 0 : ((rem > TB_BURST) ? TB_BURST : rem);
            e.lane = e.last ? ((int'(c_width) - (int'(c_cg) - 1) * TB_TOUT) & 15) : TB_TOUT;
            e.is_wr = 0;
            e.addr = c_inb + 32'(g) * c_ins + 32'(h) * c_inl + 32'(wb * TB_BURST * TB_PIXB);
            sb.push_back(e);
            n_rd++;
            if (p == 1) begin
              e.is_wr = 1;
              e.addr = c_outb + 32'(g) * c_outs + 32'(h) * c_outl + 32'(wb * TB_BURST * TB_PIXB);
              sb.push_back(e);
              n_wr++;
            end
          end
  endtask

  initial begin : drivers
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      pass_done = (cyc == pd_due) || spur_pd;
      rd_ready  = rand_rdy ? ($urandom_range(0, 2) != 0) : hold_rdy;
      wr_ready  = rand_rdy ? ($urandom_range(0, 2) != 0) : hold_rdy;
    end
  end

  initial begin : monitor
    exp_t        e;
    bit          hold_rd = 0, hold_wr = 0;
    logic [63:0] rd_snap = '0, wr_snap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_rd = 0;
        hold_wr = 0;
        continue;
      end
      if (rd_valid && wr_valid) checkOutput("rd_wr_exclusive", 1, 0);
      if (hold_rd)
        checkOutput("rd_payload_stable",
                    {20'd0, rd_valid, rd_addr, rd_pass, rd_last_grp, rd_pix_cnt, rd_lane_cnt}, rd_snap);
      if (hold_wr) checkOutput("wr_payload_stable", {31'd0, wr_valid, wr_addr}, wr_snap);
      hold_rd = rd_valid && !rd_ready;
      hold_wr = wr_valid && !wr_ready;
      rd_snap = {20'd0, rd_valid, rd_addr, rd_pass, rd_last_grp, rd_pix_cnt, rd_lane_cnt};
      wr_snap = {31'd0, wr_valid, wr_addr};
      if (rd_valid || wr_valid) valid_cycles++;
      if (gap && (rd_valid || wr_valid)) stray++;
      if (gap && pass_done) begin
        checkOutput("no_issue_while_waiting", stray, 0);
        gap = 0;
        stray = 0;
      end
      if (rd_valid && rd_ready) begin
        rd_seen++;
        if (sb.size() == 0) checkOutput("unexpected_rd", 1, 0);
        else begin
          e = sb.pop_front();
          checkOutput("rd_order_kind", 0, e.is_wr);
          checkOutput("rd_addr", rd_addr, e.addr);
          checkOutput("rd_pass", rd_pass, e.pass);
          checkOutput("rd_last_grp", rd_last_grp, e.last);
          checkOutput("rd_pix_cnt", rd_pix_cnt, e.pix);
          checkOutput("rd_lane_cnt", rd_lane_cnt, e.lane);
          if (spot_check && e.h == 1 && e.wb == 1 && e.g == 2 && !e.pass) begin
            checkOutput("spot_rd_addr", rd_addr, 32'h0100_1600);
            checkOutput("spot_pix_cnt", rd_pix_cnt, 3);
            checkOutput("spot_lane_cnt", rd_lane_cnt, 3);
          end
          if (e.last && !e.pass) begin
            gap = 1;
            pd_due = cyc + 3;
          end
        end
      end
      if (wr_valid && wr_ready) begin
        wr_seen++;
        if (sb.size() == 0) checkOutput("unexpected_wr", 1, 0);
        else begin
          e = sb.pop_front();
          checkOutput("wr_order_kind", 1, e.is_wr);
          checkOutput("wr_addr", wr_addr, e.addr);
          if (e.last) begin
            gap = 1;
            pd_due = cyc + 3;
          end
        end
      end
      if (done) begin
        done_cnt++;
        checkOutput("sb_empty_at_done", sb.size(), 0);
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] head, win, cg, height, width,
                               input logic [31:0] inb, ins, inl, outb, outs, outl,
                               output int n_rd, output int n_wr);
    int lat;
    c_head = head; c_win = win; c_cg = cg; c_height = height; c_width = width;
    c_inb = inb; c_ins = ins; c_inl = inl; c_outb = outb; c_outs = outs; c_outl = outl;
    buildExpected(n_rd, n_wr);
    rd0 = rd_seen; wr0 = wr_seen; done0 = done_cnt; valid0 = valid_cycles;
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_valid || done) break;
      @(posedge clk);
      lat++;
    end
    checkOutput("first_response_latency", lat, 2);
  endtask

  task automatic finishRun(input int n_rd, input int n_wr);
    int waited = 0;
    while (done_cnt == done0 && waited < 5000) begin
      @(posedge clk);
      waited++;
    end
    checkOutput("done_within_budget", done_cnt != done0, 1);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("done_pulses", done_cnt - done0, 1);
    checkOutput("read_count", rd_seen - rd0, n_rd);
    checkOutput("write_count", wr_seen - wr0, n_wr);
    checkOutput("busy_after_done", busy, 0);
  endtask

  task automatic runCase1(output int n_rd, output int n_wr);
    applyStimulus(16'd2, 16'd32, 16'd3, 16'd19, 16'd19,
                  32'h0100_0000, 32'd2048, 32'd1024, 32'h0200_0000, 32'd4096, 32'd2048,
                  n_rd, n_wr);
  endtask

  initial begin : main
    int  n_rd, n_wr, d_before, wbn, cg;
    bit  found;
    #3;
    checkOutput("reset_ctrl", {rd_valid, wr_valid, rd_pass, rd_last_grp, busy, done, rd_pix_cnt, rd_lane_cnt}, 0);
    checkOutput("reset_addr", {rd_addr, wr_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] case 1: nominal layer, ready held high");
    spot_check = 1;
    runCase1(n_rd, n_wr);
    #1 checkOutput("busy_in_run", busy, 1);
    finishRun(n_rd, n_wr);
    checkOutput("case1_reads", rd_seen - rd0, 24);
    checkOutput("case1_writes", wr_seen - wr0, 12);

    $display("[TB] case 2: random ready back-pressure");
    rand_rdy = 1;
    runCase1(n_rd, n_wr);
    finishRun(n_rd, n_wr);
    checkOutput("case2_reads", rd_seen - rd0, 24);
    rand_rdy = 0;

    $display("[TB] case 3: zero channel groups");
    applyStimulus(16'd2, 16'd32, 16'd0, 16'd19, 16'd19,
                  32'h10, 32'd64, 32'd32, 32'h20, 32'd64, 32'd32, n_rd, n_wr);
    finishRun(n_rd, n_wr);
    checkOutput("noop_no_valid", valid_cycles - valid0, 0);

    $display("[TB] case 4: stray pass_done while reading");
    hold_rdy = 0;
    runCase1(n_rd, n_wr);
    repeat (2) @(negedge clk);
    spur_pd = 1'b1;
    @(posedge clk);
    #2 spur_pd = 1'b0;
    repeat (2) @(posedge clk);
    hold_rdy = 1;
    finishRun(n_rd, n_wr);

    $display("[TB] case 5: reset during second tile write");
    runCase1(n_rd, n_wr);
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (wr_valid && wr_addr == c_outb + 32'd512) found = 1;
    end
    checkOutput("reach_tile2_write", found, 1);
    d_before = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_ctrl", {rd_valid, wr_valid, rd_pass, rd_last_grp, busy, done, rd_pix_cnt, rd_lane_cnt}, 0);
    checkOutput("async_reset_addr", {rd_addr, wr_addr}, 0);
    sb.delete();
    gap = 0;
    stray = 0;
    pd_due = -1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    checkOutput("no_done_after_abort", done_cnt - d_before, 0);
    runCase1(n_rd, n_wr);
    finishRun(n_rd, n_wr);
    checkOutput("rerun_reads", rd_seen - rd0, 24);

    $display("[TB] case 6: start while busy");
    runCase1(n_rd, n_wr);
    repeat (4) @(posedge clk);
    #2;
    c_head = 16'd5; c_cg = 16'd1; c_inb = 32'hDEAD_0000;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    finishRun(n_rd, n_wr);
    checkOutput("busy_start_reads", rd_seen - rd0, 24);

    $display("[TB] case 7: random layers");
    spot_check = 0;
    rand_rdy = 1;
    for (int k = 0; k < 5; k++) begin
      wbn = $urandom_range(1, 3);
      cg  = $urandom_range(1, 4);
      applyStimulus(16'($urandom_range(1, 3)), 16'(wbn * TB_BURST), 16'(cg),
                    16'($urandom_range(0, wbn * TB_BURST + 4)),
                    16'($urandom_range((cg - 1) * TB_TOUT + 1, cg * TB_TOUT)),
                    $urandom, 32'($urandom_range(0, 65535)), 32'($urandom_range(0, 65535)),
                    $urandom, 32'($urandom_range(0, 65535)), 32'($urandom_range(0, 65535)),
                    n_rd, n_wr);
      finishRun(n_rd, n_wr);
    end
    rand_rdy = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
